// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: drives PC enable/reset/source select
// from debug commands, hazard stalls and branch resolution; drains on halt.
module fetch_ctrl #(
    parameter int unsigned                ADDR_BITS    = 32,
    parameter int unsigned                DATA_WIDTH   = 32,
    parameter int unsigned                CNT_BITS     = 32,
    parameter logic [DATA_WIDTH-1:0]      HALT_WORD    = 32'hFFFF_FFFF,
    parameter int unsigned                DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_run,
    input  logic                  cmd_step,
    input  logic                  cmd_clear,
    input  logic                  stall_req,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic                  pc_enable,
    output logic                  pc_reset,
    output logic                  mux_select,
    output logic                  busy,
    output logic                  halted,
    output logic                  step_done,
    output logic [CNT_BITS-1:0]   cycle_count
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

    // Elaboration-time sanity checks on the parameter set.
    if (ADDR_BITS < 2) begin : g_bad_addr_bits
        $error("fetch_ctrl: ADDR_BITS must be at least 2");
    end
    if (DRAIN_CYCLES < 1) begin : g_bad_drain_cycles
        $error("fetch_ctrl: DRAIN_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_STEP  = 3'd3,
        S_DRAIN = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_BITS-1:0]   r_cycle_count;
    logic [DCW-1:0]        r_drain_cnt;
    logic                  r_step_done;

    logic w_fetching;
    logic w_halt_hit;
    logic w_fetch_ok;
    logic w_pc_enable;
    logic w_busy;
    logic w_clear;

    // A taken branch squashes the path carrying the halt word.
    assign w_halt_hit  = (instr_in == HALT_WORD) && !branch_taken;
    assign w_fetching  = (r_state == S_RUN) || (r_state == S_STEP);
    assign w_fetch_ok  = w_fetching && !stall_req && !w_halt_hit;
    assign w_pc_enable = w_fetch_ok || (branch_taken && w_fetching && !stall_req);
    assign w_busy      = w_fetching || (r_state == S_DRAIN);
    assign w_clear     = cmd_clear && ((r_state == S_IDLE) || (r_state == S_HALT));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_INIT:  w_next = S_IDLE;
            S_IDLE: begin
                if (cmd_clear)     w_next = S_INIT;
                else if (cmd_run)  w_next = S_RUN;
                else if (cmd_step) w_next = S_STEP;
            end
            S_RUN: begin
                if (w_halt_hit) w_next = S_DRAIN;
            end
            S_STEP: begin
                if (w_pc_enable)     w_next = S_IDLE;
                else if (w_halt_hit) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_next = S_HALT;
            end
            S_HALT: begin
                if (cmd_clear) w_next = S_INIT;
            end
            default: w_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_INIT;
            r_cycle_count <= '0;
            r_drain_cnt   <= '0;
            r_step_done   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_step_done <= (r_state == S_STEP) && w_pc_enable;

            if (w_clear) begin
                r_cycle_count <= '0;
            end else if (w_busy && (r_cycle_count != '1)) begin
                r_cycle_count <= r_cycle_count + CNT_BITS'(1);
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= (r_drain_cnt == DRAIN_LAST) ? '0 : r_drain_cnt + DCW'(1);
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    assign pc_enable   = w_pc_enable;
    assign mux_select  = branch_taken && w_pc_enable;
    assign pc_reset    = !reset || (r_state == S_INIT);
    assign busy        = w_busy;
    assign halted      = (r_state == S_HALT);
    assign step_done   = r_step_done;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl; a narrow cycle counter exposes saturation.
module tb_fetch_ctrl;

    localparam logic [31:0] H = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic        cmd_run, cmd_step, cmd_clear, stall_req, branch_taken;
    logic [31:0] instr_in;
    logic        pc_enable, pc_reset, mux_select, busy, halted, step_done;
    logic [3:0]  cycle_count;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(
        .ADDR_BITS   (32),
        .DATA_WIDTH  (32),
        .CNT_BITS    (4),
        .HALT_WORD   (32'hFFFF_FFFF),
        .DRAIN_CYCLES(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_run     (cmd_run),
        .cmd_step    (cmd_step),
        .cmd_clear   (cmd_clear),
        .stall_req   (stall_req),
        .branch_taken(branch_taken),
        .instr_in    (instr_in),
        .pc_enable   (pc_enable),
        .pc_reset    (pc_reset),
        .mux_select  (mux_select),
        .busy        (busy),
        .halted      (halted),
        .step_done   (step_done),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst, run, step, clr, stall, br;
        logic [31:0] instr;
        logic        pe, pr, mux, bsy, hlt, sd;
        logic [3:0]  cnt;
        logic [6:0]  mask;  // {pe,pr,mux,busy,halted,step_done,count}
    } vec_t;

    function automatic vec_t mkv(input string n,
                                 input logic rst, input logic run, input logic step,
                                 input logic clr, input logic stall, input logic br,
                                 input logic [31:0] instr,
                                 input logic pe, input logic pr, input logic mux,
                                 input logic bsy, input logic hlt, input logic sd,
                                 input logic [3:0] cnt,
                                 input logic [6:0] m = 7'h7F);
        vec_t v;
        v.name = n; v.rst = rst; v.run = run; v.step = step; v.clr = clr;
        v.stall = stall; v.br = br; v.instr = instr;
        v.pe = pe; v.pr = pr; v.mux = mux; v.bsy = bsy; v.hlt = hlt; v.sd = sd;
        v.cnt = cnt; v.mask = m;
        return v;
    endfunction

    // Drive on the falling edge, compare 1 time unit later, before the next rising edge.
    task automatic apply(input vec_t v);
        logic [5:0] act;
        logic [5:0] exp;
        logic       bad;
        @(negedge clk);
        reset = v.rst; cmd_run = v.run; cmd_step = v.step; cmd_clear = v.clr;
        stall_req = v.stall; branch_taken = v.br; instr_in = v.instr;
        #1;
        act = {pc_enable, pc_reset, mux_select, busy, halted, step_done};
        exp = {v.pe, v.pr, v.mux, v.bsy, v.hlt, v.sd};
        bad = (((act ^ exp) & v.mask[6:1]) !== 6'b0) ||
              (v.mask[0] && (cycle_count !== v.cnt));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got pe=%b pr=%b mux=%b busy=%b halted=%b sd=%b cnt=%0d, expected pe=%b pr=%b mux=%b busy=%b halted=%b sd=%b cnt=%0d (mask %b)",
                     v.name, act[5], act[4], act[3], act[2], act[1], act[0], cycle_count,
                     v.pe, v.pr, v.mux, v.bsy, v.hlt, v.sd, v.cnt, v.mask);
        end
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_clear = 1'b0;
        stall_req = 1'b0; branch_taken = 1'b0; instr_in = '0;

        //                 name            rst run stp clr stl br instr  pe pr mx bsy hlt sd cnt
        tbl.push_back(mkv("rst_pc_reset",   0, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0, 7'b0100000));
        tbl.push_back(mkv("rst_hold",       0, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("init",           1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("idle",           1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv("idle_run",       1, 1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mkv("run_fetch",  1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 4'(i)));
        tbl.push_back(mkv("run_cnt10",      1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 10));
        tbl.push_back(mkv("run_stall_a",    1, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 0, 0, 11));
        tbl.push_back(mkv("run_stall_b",    1, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 0, 0, 12));
        tbl.push_back(mkv("run_resume",     1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 13));
        tbl.push_back(mkv("run_branch",     1, 0, 0, 0, 0, 1, 32'h0,  1, 0, 1, 1, 0, 0, 14));
        tbl.push_back(mkv("run_after_br",   1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 15));
        tbl.push_back(mkv("run_saturate",   1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 15));
        tbl.push_back(mkv("run_stall_br",   1, 0, 0, 0, 1, 1, 32'h0,  0, 0, 0, 1, 0, 0, 15));
        tbl.push_back(mkv("run_ign_cmds",   1, 1, 1, 1, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 15));

        foreach (tbl[i]) apply(tbl[i]);

        // Halt in RUN, drain, commands ignored until clear.
        apply(mkv("halt_fetch",      1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 15));
        apply(mkv("drain0_run_ign",  1, 1, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 15));
        apply(mkv("drain1_clr_ign",  1, 0, 0, 1, 0, 0, H,      0, 0, 0, 1, 0, 0, 15));
        apply(mkv("drain2",          1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 15));
        apply(mkv("drain3",          1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 15));
        apply(mkv("halt_run_ign",    1, 1, 0, 0, 0, 0, H,      0, 0, 0, 0, 1, 0, 15));
        apply(mkv("halt_step_ign",   1, 0, 1, 0, 0, 0, H,      0, 0, 0, 0, 1, 0, 15));
        apply(mkv("halt_clear",      1, 0, 0, 1, 0, 0, H,      0, 0, 0, 0, 1, 0, 15));
        apply(mkv("clr_init",        1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));
        apply(mkv("clr_idle",        1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));

        // Single step held off by a two-cycle stall.
        apply(mkv("idle_step",       1, 0, 1, 0, 1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));
        apply(mkv("step_stall_a",    1, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 0, 0, 0));
        apply(mkv("step_stall_b",    1, 0, 0, 0, 1, 0, 32'h0,  0, 0, 0, 1, 0, 0, 1));
        apply(mkv("step_fetch",      1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 2));
        apply(mkv("step_done_pulse", 1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 1, 3));
        apply(mkv("step_done_end",   1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 3));

        // Step that lands on the halt word drains without a step_done pulse.
        apply(mkv("idle_step2",      1, 0, 1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 3));
        apply(mkv("step_halt",       1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 3));
        apply(mkv("sdrain0_no_sd",   1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 4));
        apply(mkv("sdrain1",         1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 5));
        apply(mkv("sdrain2",         1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 6));
        apply(mkv("sdrain3",         1, 0, 0, 0, 0, 0, H,      0, 0, 0, 1, 0, 0, 7));
        apply(mkv("shalt_clear",     1, 0, 0, 1, 0, 0, H,      0, 0, 0, 0, 1, 0, 8));
        apply(mkv("sinit",           1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));

        // Command priority in IDLE: clear beats run beats step.
        apply(mkv("prio_clear",      1, 1, 1, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));
        apply(mkv("prio_init",       1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));
        apply(mkv("prio_run",        1, 1, 1, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));

        // Taken branch masks the halt word; then reset aborts the run.
        apply(mkv("br_over_halt",    1, 0, 0, 0, 0, 1, H,      1, 0, 1, 1, 0, 0, 0));
        apply(mkv("still_run",       1, 0, 0, 0, 0, 0, 32'h0,  1, 0, 0, 1, 0, 0, 1));
        apply(mkv("mid_reset",       0, 0, 0, 0, 0, 0, 32'h0,  1, 1, 0, 1, 0, 0, 2));
        apply(mkv("post_reset_init", 1, 0, 0, 0, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 0));
        apply(mkv("final_idle",      1, 0, 0, 0, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
